// File: rtl/rv_core_pkg.sv
// Shared core definitions for the fetch front end: PC generator state,
// address width and instruction size. Used by pc_gen, instr_fetch and decode.
package rv_core_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = '0;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } pc_state_e;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Instruction-memory request bus between pc_gen (master) and instr_fetch /
// instruction memory (slave).
interface pc_gen_if #(
  parameter int XLEN = rv_core_pkg::XLEN
);

  logic            mem_req_o;
  logic            mem_gnt_i;
  logic [XLEN-1:0] program_count;

  modport master (
    output mem_req_o,
    output program_count,
    input  mem_gnt_i
  );

  modport slave (
    input  mem_req_o,
    input  program_count,
    output mem_gnt_i
  );

endinterface

// File: rtl/pc_gen.sv
// Program-counter generation stage: req/gnt fetch requests, +4 advance, stall,
// redirect and misaligned-target trap. Optional stall counter: PC_GEN_PERF_CNT_EN.
module pc_gen #(
  parameter int                   XLEN         = rv_core_pkg::XLEN,
  parameter logic [XLEN-1:0]      RESET_VECTOR = rv_core_pkg::DEFAULT_RESET_VECTOR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  pc_gen_if.master        bus,
  output logic            fetch_done_o,
  output logic [XLEN-1:0] fetched_pc_o,
  output logic            misalign_o,
  output logic [31:0]     stall_cnt_o
);

  import rv_core_pkg::*;

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fetched_pc_q, fetched_pc_d;
  logic            fetch_done_q, fetch_done_d;
  logic            misalign_q, misalign_d;

  logic req;
  logic grant;
  logic redirect_take;
  logic target_ok;

  assign redirect_take = redirect_valid_i && (state_q != BOOT);
  assign target_ok     = is_word_aligned(redirect_pc_i[1:0]);
  assign grant         = req && bus.mem_gnt_i;

  // NOTE: state flops use <= so every flop samples pre-edge values together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= BOOT;
    else       state_q <= state_d;
  end

  // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:         state_d = FETCH;
      FETCH, FAULT: if (redirect_take) state_d = target_ok ? FETCH : FAULT;
      default:      state_d = BOOT;
    endcase
  end

  always_comb begin
    req = (state_q == FETCH) && !stall_i;
  end

  // Redirect has priority over the +4 advance; a same-cycle grant still reports.
  always_comb begin
    pc_d         = pc_q;
    misalign_d   = misalign_q;
    fetch_done_d = grant;
    fetched_pc_d = grant ? pc_q : fetched_pc_q;
    if (redirect_take) begin
      pc_d       = redirect_pc_i;
      misalign_d = !target_ok;
    end else if (grant) begin
      pc_d = pc_q + XLEN'(INSTR_BYTES);
    end
  end

  // NOTE: every flop here is control-visible, so all take the async reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_VECTOR;
      fetched_pc_q <= '0;
      fetch_done_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      fetched_pc_q <= fetched_pc_d;
      fetch_done_q <= fetch_done_d;
      misalign_q   <= misalign_d;
    end
  end

`ifdef PC_GEN_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if ((state_q == FETCH) && stall_i && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

  assign bus.mem_req_o     = req;
  assign bus.program_count = pc_q;
  assign fetch_done_o      = fetch_done_q;
  assign fetched_pc_o      = fetched_pc_q;
  assign misalign_o        = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector table, hand-written corner
// sequences, then randomized traffic against a behavioural fetch model.
module tb_pc_gen;

`ifdef PC_GEN_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        fetch_done_o;
  logic [31:0] fetched_pc_o;
  logic        misalign_o;
  logic [31:0] stall_cnt_o;

  pc_gen_if #(.XLEN(32)) bus ();

  pc_gen #(
    .XLEN        (32),
    .RESET_VECTOR(32'h0000_0000)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall_i         (stall_i),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i   (redirect_pc_i),
    .bus             (bus),
    .fetch_done_o    (fetch_done_o),
    .fetched_pc_o    (fetched_pc_o),
    .misalign_o      (misalign_o),
    .stall_cnt_o     (stall_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic rv, input logic [31:0] rpc, input logic g);
    stall_i          = s;
    redirect_valid_i = rv;
    redirect_pc_i    = rpc;
    bus.mem_gnt_i    = g;
  endtask

  // Leaves the bench at a falling edge with reset just released (DUT in BOOT).
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        gnt;
    logic        e_req;
    logic [31:0] e_pc;
    logic        e_done;
    logic [31:0] e_fpc;
    logic        e_mis;
  } vec_t;

  vec_t tbl [17];

  typedef enum {M_BOOT, M_RUN, M_TRAP} mode_e;

  initial begin
    // Registered expectations are the values seen before this row's clock edge.
    tbl[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b0, 32'h0,   1'b0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b1, 32'h0,   1'b0};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h8,   1'b1, 32'h4,   1'b0};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h8,   1'b0, 32'h0,   1'b0};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h8,   1'b0, 32'h0,   1'b0};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   1'b0, 32'h0,   1'b0};
    tbl[7]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'hC,   1'b1, 32'h8,   1'b0};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'hC,   1'b0, 32'h0,   1'b0};
    tbl[9]  = '{1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 32'hC,   1'b0, 32'h0,   1'b0};
    tbl[10] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h100, 1'b1, 32'hC,   1'b0};
    tbl[11] = '{1'b0, 1'b1, 32'h102, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   1'b0};
    tbl[12] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h102, 1'b1, 32'h100, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h102, 1'b0, 32'h0,   1'b1};
    tbl[14] = '{1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 32'h102, 1'b0, 32'h0,   1'b1};
    tbl[15] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   1'b0};
    tbl[16] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h204, 1'b1, 32'h200, 1'b0};

    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    check("reset req",      bus.mem_req_o,     32'h0);
    check("reset pc",       bus.program_count, 32'h0);
    check("reset done",     fetch_done_o,      32'h0);
    check("reset fpc",      fetched_pc_o,      32'h0);
    check("reset misalign", misalign_o,        32'h0);
    check("reset stallcnt", stall_cnt_o,       32'h0);

    // ---------------- directed table ----------------
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].stall, tbl[i].rv, tbl[i].rpc, tbl[i].gnt);
      #1;
      check($sformatf("row%0d req", i),  bus.mem_req_o,     tbl[i].e_req);
      check($sformatf("row%0d pc", i),   bus.program_count, tbl[i].e_pc);
      check($sformatf("row%0d done", i), fetch_done_o,      tbl[i].e_done);
      if (tbl[i].e_done)
        check($sformatf("row%0d fpc", i), fetched_pc_o, tbl[i].e_fpc);
      check($sformatf("row%0d mis", i),  misalign_o,        tbl[i].e_mis);
      @(negedge clk);
    end
    check("table stallcnt", stall_cnt_o, PERF ? 32'd2 : 32'd0);

    // ---------------- redirect during BOOT is ignored ----------------
    do_reset();
    drive(1'b0, 1'b1, 32'h43, 1'b1);
    #1;
    check("boot req", bus.mem_req_o, 32'h0);
    @(negedge clk);
    check("boot redirect pc",  bus.program_count, 32'h0);
    check("boot redirect mis", misalign_o,        32'h0);

    // ---------------- wrap at top of address space ----------------
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    @(negedge clk);
    check("wrap setup pc", bus.program_count, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check("wrap pc",   bus.program_count, 32'h0);
    check("wrap done", fetch_done_o,      32'h1);
    check("wrap fpc",  fetched_pc_o,      32'hFFFF_FFFC);

    // ---------------- redirect while stalled is taken ----------------
    drive(1'b1, 1'b1, 32'h300, 1'b1);
    #1;
    check("stall redirect req", bus.mem_req_o, 32'h0);
    @(negedge clk);
    check("stall redirect pc", bus.program_count, 32'h300);
    check("stall redirect cnt", stall_cnt_o, PERF ? 32'd1 : 32'd0);

    // ---------------- async reset mid-request ----------------
    drive(1'b0, 1'b1, 32'h301, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("pre-reset mis", misalign_o, 32'h1);
    drive(1'b0, 1'b1, 32'h400, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    check("pre-reset req", bus.mem_req_o, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("midreset req",  bus.mem_req_o,     32'h0);
    check("midreset pc",   bus.program_count, 32'h0);
    check("midreset done", fetch_done_o,      32'h0);
    check("midreset mis",  misalign_o,        32'h0);
    check("midreset cnt",  stall_cnt_o,       32'h0);

    // ---------------- randomized traffic vs model ----------------
    begin
      mode_e       mode;
      logic [31:0] m_pc, m_fpc, m_cnt;
      logic        m_done, m_mis;
      logic        s, rv, g, exp_req, granted;
      logic [31:0] rpc;

      do_reset();
      mode = M_BOOT; m_pc = 32'h0; m_fpc = 32'h0; m_cnt = 32'h0;
      m_done = 1'b0; m_mis = 1'b0;

      for (int cyc = 0; cyc < 3000; cyc++) begin
        s  = ($urandom_range(0, 3) == 0);
        g  = ($urandom_range(0, 2) != 0);
        rv = ($urandom_range(0, 5) == 0);
        case ($urandom_range(0, 3))
          0:       rpc = $urandom & 32'hFFFF_FFFC;
          1:       rpc = $urandom;
          2:       rpc = 32'hFFFF_FFF8 + 32'($urandom_range(0, 1) * 4);
          default: rpc = 32'($urandom_range(0, 63)) * 4;
        endcase
        drive(s, rv, rpc, g);
        #1;
        exp_req = (mode == M_RUN) && !s;
        check("rnd req",  bus.mem_req_o,     exp_req);
        check("rnd pc",   bus.program_count, m_pc);
        check("rnd done", fetch_done_o,      m_done);
        if (m_done) check("rnd fpc", fetched_pc_o, m_fpc);
        check("rnd mis",  misalign_o,        m_mis);
        check("rnd cnt",  stall_cnt_o,       PERF ? m_cnt : 32'h0);

        granted = exp_req && g;
        if ((mode == M_RUN) && s && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 1;
        m_done = granted;
        if (granted) m_fpc = m_pc;
        if (mode == M_BOOT) begin
          mode = M_RUN;
        end else if (rv) begin
          m_pc = rpc;
          if (rpc % 4 == 0) begin
            mode  = M_RUN;
            m_mis = 1'b0;
          end else begin
            mode  = M_TRAP;
            m_mis = 1'b1;
          end
        end else if (granted) begin
          m_pc = m_pc + 4;
        end
        @(negedge clk);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
